// File: rtl/sram_responder.sv
// sram_responder: single-port SRAM array behind a FREE/BUSY/DONE/ERROR handshake.
// Latency: request sampled in FREE, then LATENCY cycles BUSY, one cycle DONE, then FREE.
// Backpressure: initiator holds wen/ren until DONE; requests are only sampled in FREE.
module sram_responder #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wen,
  input  logic               ren,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [DATA_W-1:0]  wdata,
  output logic [DATA_W-1:0]  rdata,
  output logic [1:0]         sram_state,
  output logic [COUNT_W-1:0] access_count
);

  // Latency counter only needs to reach LATENCY-1.
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  // Array index width; addresses at or above DEPTH never reach the array.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW1   = ADDR_W + 1;

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(LATENCY - 1);
  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [AW1-1:0]   DEPTH_L = AW1'(DEPTH);

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                op_wr;
  logic                req_bad;
  logic                commit;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Simultaneous read+write, or any address beyond the array, is rejected.
  assign req_bad    = (wen && ren) || ({1'b0, addr} >= DEPTH_L);
  // Last BUSY cycle: the access lands on the BUSY->DONE edge.
  assign commit     = (state == ST_BUSY) && (cnt == LAST);
  // State code is the registered FSM state itself, so it cannot glitch.
  assign sram_state = state;

  // Handshake FSM with latched request, read data and completion counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_FREE;
      cnt          <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      op_wr        <= 1'b0;
      rdata        <= '0;
      access_count <= '0;
    end else begin
      case (state)
        ST_FREE: begin
          if (wen || ren) begin
            if (req_bad) begin
              state <= ST_ERROR;
            end else begin
              state  <= ST_BUSY;
              cnt    <= '0;
              addr_q <= addr[IDX_W-1:0];
              op_wr  <= wen;
              if (wen) wdata_q <= wdata;
            end
          end
        end
        ST_BUSY: begin
          if (commit) begin
            state        <= ST_DONE;
            access_count <= access_count + 1'b1;
            if (!op_wr) rdata <= mem[addr_q];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE:  state <= ST_FREE;
        default:  state <= ST_FREE;
      endcase
    end
  end

  // Array write; contents survive reset, and a reset during BUSY leaves state FREE so nothing commits.
  always_ff @(posedge clk) begin
    if (commit && op_wr) mem[addr_q] <= wdata_q;
  end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Behavioural and synthesizable single-port SRAM responder serving the buffer-side SRAM request interface (wen/ren/addr/wdata in; rdata/sram_state out).
- Sits between the SRAM buffer controller and the storage array. Models a fixed multi-cycle access latency and reports its progress on the 2-bit sram_state code.
- Provides the FREE → BUSY → DONE → FREE sequence that the buffer's wait states depend on.

Parameters:
- ADDR_W, 10, word address width.
- DATA_W, 32, word width.
- DEPTH, 1024, number of words; must be ≤ 2^ADDR_W.
- LATENCY, 2, number of cycles in BUSY per access; must be ≥ 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wen  in  1  write request, level; held by the initiator until DONE is seen.
- ren  in  1  read request, level; held by the initiator until DONE is seen.
- addr  in  ADDR_W  word address.
- wdata  in  DATA_W  write data.
- rdata  out  DATA_W  read data; valid while sram_state == DONE.
- sram_state  out  2  0 = FREE, 1 = BUSY, 2 = DONE, 3 = ERROR.
- access_count  out  16  number of completed (DONE) accesses; wraps at 0xFFFF → 0.

Behaviour:
- Reset (rst high, asynchronous):
  - State goes to FREE; sram_state = 0; rdata = 0; access_count = 0.
  - Latched address, data and operation are cleared; the latency counter is cleared.
  - Memory contents are not reset.
- The FSM state is registered; sram_state is decoded directly from it, so it is glitch-free.
- FREE:
  - Samples requests every cycle.
  - wen & ren together → ERROR.
  - (wen | ren) with addr ≥ DEPTH → ERROR.
  - wen alone → latch addr/wdata, op = write, go BUSY.
  - ren alone → latch addr, op = read, go BUSY.
  - No request → stay in FREE.
- BUSY:
  - The latency counter starts at 0 on entry and increments each cycle.
  - When the count reaches LATENCY-1, go to DONE at the next edge. BUSY therefore lasts exactly LATENCY cycles.
  - Input changes during BUSY are ignored; the latched values are used.
  - Dropping the request mid-BUSY does not abort the access.
- Transition BUSY → DONE (same edge):
  - Write: mem[latched addr] ← latched wdata.
  - Read: rdata ← mem[latched addr].
  - access_count increments.
- DONE:
  - Lasts exactly one cycle; the next state is always FREE.
  - Requests are not sampled in DONE.
  - rdata is stable for the whole cycle.
- ERROR:
  - Lasts one cycle, then FREE.
  - No memory write; rdata unchanged; access_count unchanged.
- rdata holds its last read value through FREE/BUSY/ERROR and through writes. Only a completed read updates it.
- Timing, from the edge that samples the request in FREE: sram_state = 1 for LATENCY cycles, then 2 for 1 cycle, then 0.
  - First possible new sample is in the FREE cycle after DONE.
  - Back-to-back accesses therefore occupy LATENCY+2 cycles each.
- Back-to-back requests:
  - A request still held in the FREE cycle after DONE is treated as a new access with the current addr/wdata.
  - This supports the initiator's low-word/high-word pairing, where addr advances in the cycle after DONE.
- The initiator waits for sram_state == 0 before leaving its send state. FREE is reached exactly one cycle after DONE, so it never stalls.
- Reset asserted mid-BUSY: the pending write is discarded (memory unchanged), a pending read does not update rdata, and access_count is not incremented.
- Read after write to the same address returns the new data: the write commits before any later access can start.

Test Plan:
- Basic write/read, LATENCY = 2:
  - Hold wen, addr = 0x004, wdata = 0xDEADBEEF → sram_state reads 1, 1, 2, 0; access_count = 1.
  - Then hold ren, addr = 0x004 → during the DONE cycle rdata = 0xDEADBEEF; access_count = 2.
- Paired 64-bit transfer:
  - Write 0x11111111 to addr 0x010 and 0x22222222 to addr 0x011, advancing addr and wdata in the cycle after the first DONE with wen held throughout → two DONE pulses 4 cycles apart.
  - Read both back → 0x11111111, then 0x22222222.
- Input changes in BUSY: start write addr = 5, wdata = 0xA5A5A5A5, then change addr to 6 and wdata to 0 during BUSY → mem[5] = 0xA5A5A5A5 and mem[6] unchanged (verify by reads).
- Errors:
  - wen & ren together → sram_state = 3 for 1 cycle, then 0; no write; access_count unchanged.
  - With DEPTH = 512, ren at addr 0x200 → sram_state = 3; rdata unchanged.
- Reset mid-access: write 0x12345678 to addr 7, assert rst in the second BUSY cycle → sram_state = 0, rdata = 0, access_count = 0 immediately; a subsequent read of addr 7 returns the previously written value (0xCAFEF00D preloaded), not 0x12345678.
- Latency sweep and wrap:
  - With LATENCY = 1 and LATENCY = 5 → BUSY lasts exactly 1 and 5 cycles respectively.
  - Drive 65536 reads → access_count wraps to 0.
